// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch and load/store
module mem_port_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int MEM_LAT      = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [15:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [15:0]       d_wdata,
    output logic              d_ack,
    output logic [15:0]       d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    output logic              busy,
    output logic              owner
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t     r_state;
    logic [3:0] r_cnt;
    logic [3:0] r_streak;
    logic       r_we;
    logic       w_dwin;
    // data wins unless fetch is pending and has waited out the starvation limit
    assign w_dwin = d_req && (!if_req || r_streak < 4'(STARVE_LIMIT));
    // transaction sequencer; every output is registered
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_streak  <= '0;
            r_we      <= 1'b0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            owner     <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            case (r_state)
                IDLE: if (if_req || d_req) begin
                    r_state  <= ISSUE;
                    busy     <= 1'b1;
                    mem_en   <= 1'b1;
                    mem_we   <= w_dwin && d_we;
                    r_we     <= w_dwin && d_we;
                    owner    <= w_dwin;
                    mem_addr <= w_dwin ? d_addr : if_addr;
                    if (w_dwin) mem_wdata <= d_wdata;
                    r_streak <= (w_dwin && if_req) ? ((r_streak < 4'(STARVE_LIMIT)) ? r_streak + 4'd1 : r_streak) : 4'd0;
                end
                ISSUE: begin
                    r_state <= WAIT;
                    r_cnt   <= 4'(MEM_LAT);
                end
                WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= RESP;
                        if (owner) begin
                            d_ack <= 1'b1;
                            if (!r_we) d_rdata <= mem_rdata;
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random requesters and memory model checked against a transaction-level reference
module tb_mem_port_arbiter;
    localparam int AW = 10;
    localparam int LAT = 2;
    localparam int LIM = 3;
    logic          clk = 0;
    logic          reset = 1;
    logic          if_req = 0, d_req = 0, d_we = 0;
    logic [AW-1:0] if_addr = 0, d_addr = 0;
    logic [15:0]   d_wdata = 0;
    logic          if_ack, d_ack, mem_en, mem_we, busy, owner;
    logic [15:0]   if_rdata, d_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    int errors = 0, checks = 0;

    mem_port_arbiter #(.ADDR_W(AW), .MEM_LAT(LAT), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .owner(owner));

    always #5 clk = ~clk;

    // memory: read data appears exactly LAT cycles after the strobe, junk otherwise
    logic [15:0] mem [1024];
    logic [15:0] ref_mem [1024];
    logic [15:0] pipe [LAT];
    logic        pv [LAT] = '{default: 1'b0};
    logic [15:0] junk = 16'hdead;
    assign mem_rdata = pv[LAT-1] ? pipe[LAT-1] : junk;
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        pipe[0] <= mem[mem_addr];
        pv[0]   <= mem_en && !mem_we;
        for (int k = 1; k < LAT; k++) begin
            pipe[k] <= pipe[k-1];
            pv[k]   <= pv[k-1];
        end
        junk <= 16'($urandom);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference: ph counts cycles into the current transaction (0 = idle)
    int          ph = 0, streak = 0;
    logic        m_owner = 0, m_we = 0;
    logic [AW-1:0] m_addr = 0, e_addr = 0;
    logic [15:0] m_wdata = 0, e_wdata = 0, e_ird = 0, e_drd = 0;
    logic        drop_if = 0, drop_d = 0, ack_now;
    bit          dwin;

    task automatic cycle(input int p_if, input int p_d, input int p_rst);
        @(posedge clk); #1;
        reset = 1'b0;
        if (drop_if) if_req = 1'b0;
        if (drop_d)  d_req = 1'b0;
        drop_if = 0; drop_d = 0;
        if (!if_req && $urandom_range(0, 99) < p_if) begin
            if_req = 1'b1; if_addr = AW'($urandom_range(0, 15));
        end
        if (!d_req && $urandom_range(0, 99) < p_d) begin
            d_req = 1'b1; d_addr = AW'($urandom_range(0, 15));
            d_we = 1'($urandom); d_wdata = 16'($urandom);
        end
        if ($urandom_range(0, 99) < p_rst) reset = 1'b1;
        #1;
        ack_now = (ph == LAT + 2);
        if (ack_now) begin
            if (!m_owner) e_ird = ref_mem[m_addr];
            else if (!m_we) e_drd = ref_mem[m_addr];
        end
        chk("busy", busy, ph != 0);
        chk("mem_en", mem_en, ph == 1);
        chk("mem_we", mem_we, ph == 1 && m_we);
        chk("mem_addr", mem_addr, e_addr);
        if (ph == 1 && m_we) chk("mem_wdata", mem_wdata, e_wdata);
        chk("if_ack", if_ack, ack_now && !m_owner);
        chk("d_ack", d_ack, ack_now && m_owner);
        chk("owner", owner, m_owner);
        chk("if_rdata", if_rdata, e_ird);
        chk("d_rdata", d_rdata, e_drd);
        if (ph == 1 && m_we) ref_mem[m_addr] = m_wdata;
        if (reset) begin
            ph = 0; streak = 0; m_owner = 0; e_addr = 0; e_wdata = 0; e_ird = 0; e_drd = 0;
            drop_if = 1; drop_d = 1;
        end else if (ph == 0) begin
            if (if_req || d_req) begin
                dwin = d_req && (!if_req || streak < LIM);
                streak = (dwin && if_req) ? ((streak < LIM) ? streak + 1 : streak) : 0;
                m_owner = dwin;
                m_we = dwin && d_we;
                m_addr = dwin ? d_addr : if_addr;
                m_wdata = d_wdata;
                e_addr = m_addr;
                if (dwin) e_wdata = d_wdata;
                ph = 1;
            end
        end else if (ack_now) begin
            ph = 0;
            if (m_owner) drop_d = 1; else drop_if = 1;
        end else ph++;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 16'($urandom);
            ref_mem[i] = mem[i];
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_if_ack", if_ack, 0);
        chk("rst_d_ack", d_ack, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        reset = 1'b0;
        for (int c = 0; c < 600; c++) cycle(40, 40, 2);
        for (int c = 0; c < 300; c++) cycle(100, 100, 0);
        for (int c = 0; c < 200; c++) cycle(100, 0, 0);
        for (int c = 0; c < 400; c++) cycle(60, 70, 3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
